opb_register_simulink2ppc_snap: RTL and testbench
=================================================

// Module: opb_register_simulink2ppc_snap
// PURPOSE
//  OPB slave that returns fabric (Simulink) data to the PPC host: read-only data word, status word, optional timestamp.
//  Captures user_data_in on a user_data_valid strobe; tracks new-data and overrun flags and counts updates.
//  Single-clock block; the user logic runs on OPB_Clk. Sits on the same OPB as the ppc2simulink registers.
// PARAMETERS
//  C_BASEADDR    32'h01010800  first byte address decoded
//  C_HIGHADDR    32'h010108FF  last byte address decoded
//  C_OPB_AWIDTH  32            OPB address width
//  C_OPB_DWIDTH  32            OPB data width
//  C_FAMILY      "virtex6"     target family, informational only
// PORTS
//  OPB_Clk          in   1       single clock for bus and user side
//  OPB_Rst_n        in   1       asynchronous, active-low reset
//  OPB_ABus         in   [0:31]  byte address
//  OPB_BE           in   [0:3]   byte enables; BE[3] covers DBus[24:31]
//  OPB_DBus         in   [0:31]  write data
//  OPB_RNW          in   1       1 = read, 0 = write
//  OPB_select       in   1       transfer request
//  OPB_seqAddr      in   1       ignored; no burst support
//  Sl_DBus          out  [0:31]  read data; zero except during read ack (OR-bus)
//  Sl_xferAck       out  1       one-cycle transfer acknowledge
//  Sl_errAck        out  1       tied 0
//  Sl_retry         out  1       tied 0
//  Sl_toutSup       out  1       tied 0
//  user_data_in     in   [31:0]  fabric value to publish
//  user_data_valid  in   1       capture strobe, one cycle per update
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE; data, count, flags and timestamp cleared.
//  Reset asserted mid-transfer returns to IDLE with no ack issued.
//  hit = OPB_select && C_BASEADDR <= OPB_ABus <= C_HIGHADDR.
//  Word index = byte address bits [3:2], i.e. OPB_ABus[28:29].
//  Address map: 0 = DATA (RO), 1 = STATUS (R/W1C), 2 = TIMESTAMP (RO), 3 = reserved (reads 0).
//  FSM states:
//   IDLE: go to ACK on hit.
//   ACK: Sl_xferAck = 1 for exactly one cycle; Sl_DBus = word if OPB_RNW, else 0; go to DONE.
//   DONE: hold until OPB_select is low, then go to IDLE. No double ack while select is held.
//  Latency: hit sampled at edge k; ack high in cycle k+1. Outputs are registered.
//  STATUS = {upd_cnt[15:0], 14'b0, overrun, new_flag}.
//  user_data_valid:
//   data_reg <= user_data_in; upd_cnt += 1, wrapping 0xFFFF -> 0; new_flag <= 1.
//   If new_flag is already 1, overrun <= 1 (sticky).
//  DATA read ack clears new_flag. Same-cycle valid wins: flag stays 1, and the read returns the pre-update data.
//  STATUS write with BE[3] = 1:
//   DBus[31] = 1 clears overrun; DBus[30] = 1 clears upd_cnt.
//   Same-cycle valid still sets new_flag; upd_cnt becomes 1 when cleared and incremented together.
//  Writes to DATA, TIMESTAMP or reserved are acked and ignored. Byte enables are ignored on reads.
// CONFIGURATION
//  SIM2PPC_TIMESTAMP_EN defined:
//   32-bit free-running cycle counter, wrapping, reset to 0.
//   ts_reg captures the counter on user_data_valid; word 2 reads ts_reg.
//  SIM2PPC_TIMESTAMP_EN undefined: counter and ts_reg absent; word 2 reads 0.
// STRUCTURE
//  Package opb_sim2ppc_pkg holds:
//   word offsets WORD_DATA=0, WORD_STATUS=1, WORD_TS=2;
//   FSM state enum {IDLE, ACK, DONE};
//   status bit positions NEW_BIT, OVR_BIT, CNT_LSB.
//  Sub-module opb_slave_xfer_fsm: address decode plus IDLE/ACK/DONE handshake.
//   Exports ack_rd and ack_wr pulses and the word index.
//  The top level holds the capture registers, flags, counters and read mux.
// TESTING
//  1. Reset, then valid with 0xDEADBEEF, then read word 0.
//     -> Ack 1 cycle after select; DBus = 0xDEADBEEF; STATUS then reads 0x00010000.
//  2. Two valids with no read in between, then read STATUS.
//     -> 0x00020003 (cnt 2, overrun, new).
//     Then write 0x00000001 with BE=4'b0001 -> STATUS reads 0x00020001.
//  3. Valid in the same cycle as the DATA read ack.
//     -> Read returns the old value; new_flag stays 1; next read returns the new value.
//  4. Hold OPB_select high 5 cycles.
//     -> Exactly one Sl_xferAck; Sl_DBus is 0 outside the ack cycle.
//     An address outside [BASE,HIGH] gives no ack.
//  5. Drop OPB_Rst_n in the ACK-pending cycle.
//     -> No ack; all registers are 0 and STATUS reads 0 after reset.
//     With SIM2PPC_TIMESTAMP_EN: valid at cycle 100 -> word 2 reads 100 +/- fixed pipeline offset.

Source files
------------

// File: rtl/opb_sim2ppc_pkg.sv
// Shared definitions for the simulink-to-PPC snapshot register block.
// Holds the word map, the handshake states and the STATUS word layout.
package opb_sim2ppc_pkg;

  localparam logic [1:0] WORD_DATA   = 2'd0;
  localparam logic [1:0] WORD_STATUS = 2'd1;
  localparam logic [1:0] WORD_TS     = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    DONE = 2'd2
  } xfer_state_e;

  // STATUS word layout: {upd_cnt[15:0], 14'b0, overrun, new_flag}
  localparam int NEW_BIT = 0;
  localparam int OVR_BIT = 1;
  localparam int CNT_LSB = 16;
  localparam int CNT_W   = 16;

  // Write-one-to-clear controls, in OPB big-endian bit numbering.
  localparam int CLR_OVR_DBIT = 31;
  localparam int CLR_CNT_DBIT = 30;
  localparam int STATUS_BE    = 3;

  function automatic logic [31:0] pack_status(input logic [CNT_W-1:0] cnt,
                                              input logic             ovr,
                                              input logic             nflag);
    logic [31:0] s;
    s                    = '0;
    s[CNT_LSB +: CNT_W]  = cnt;
    s[OVR_BIT]           = ovr;
    s[NEW_BIT]           = nflag;
    return s;
  endfunction

endpackage

// File: rtl/opb_slave_xfer_fsm.sv
// OPB slave address decode and IDLE/ACK/DONE handshake.
// Issues one registered ack per select assertion; latches direction and word index at the hit.
module opb_slave_xfer_fsm
  import opb_sim2ppc_pkg::*;
#(
  parameter int unsigned               C_OPB_AWIDTH = 32,
  parameter logic [C_OPB_AWIDTH-1:0]   C_BASEADDR   = 32'h0101_0800,
  parameter logic [C_OPB_AWIDTH-1:0]   C_HIGHADDR   = 32'h0101_08FF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_select,
  input  logic [0:C_OPB_AWIDTH-1] i_abus,
  input  logic                  i_rnw,
  output logic                  o_ack,
  output logic                  o_ack_rd,
  output logic                  o_ack_wr,
  output logic [1:0]            o_word_idx
);

  xfer_state_e r_state;
  xfer_state_e w_next;
  logic        r_rnw;
  logic [1:0]  r_idx;
  logic        w_hit;

  assign w_hit = i_select && (i_abus >= C_BASEADDR) && (i_abus <= C_HIGHADDR);

  // NOTE: next-state is assigned a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_hit) w_next = ACK;
      ACK:     w_next = DONE;
      DONE:    if (!i_select) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rnw   <= 1'b0;
      r_idx   <= WORD_DATA;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_hit) begin
        r_rnw <= i_rnw;
        r_idx <= i_abus[C_OPB_AWIDTH-4:C_OPB_AWIDTH-3];
      end
    end
  end

  assign o_ack      = (r_state == ACK);
  assign o_ack_rd   = o_ack &  r_rnw;
  assign o_ack_wr   = o_ack & ~r_rnw;
  assign o_word_idx = r_idx;

endmodule

// File: rtl/opb_register_simulink2ppc_snap.sv
// OPB slave publishing a fabric data word to the PPC: DATA, STATUS (W1C) and optional TIMESTAMP.
// Define SIM2PPC_TIMESTAMP_EN to add the free-running cycle counter and capture register on word 2.
module opb_register_simulink2ppc_snap
  import opb_sim2ppc_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0101_0800,
  parameter logic [31:0] C_HIGHADDR   = 32'h0101_08FF,
  parameter int unsigned C_OPB_AWIDTH = 32,
  parameter int unsigned C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex6"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  input  logic [31:0]             user_data_in,
  input  logic                    user_data_valid
);

  logic             w_ack;
  logic             w_ack_rd;
  logic             w_ack_wr;
  logic [1:0]       w_word_idx;

  logic [31:0]      r_data;
  logic [CNT_W-1:0] r_cnt;
  logic             r_new;
  logic             r_ovr;

  logic             w_status_wr;
  logic             w_clr_ovr;
  logic             w_clr_cnt;
  logic             w_data_rd;
  logic [31:0]      w_ts_word;
  logic [31:0]      w_rd_word;
  logic             w_unused;

  opb_slave_xfer_fsm #(
    .C_OPB_AWIDTH (C_OPB_AWIDTH),
    .C_BASEADDR   (C_BASEADDR[C_OPB_AWIDTH-1:0]),
    .C_HIGHADDR   (C_HIGHADDR[C_OPB_AWIDTH-1:0])
  ) u_xfer (
    .clk        (OPB_Clk),
    .rst_n      (OPB_Rst_n),
    .i_select   (OPB_select),
    .i_abus     (OPB_ABus),
    .i_rnw      (OPB_RNW),
    .o_ack      (w_ack),
    .o_ack_rd   (w_ack_rd),
    .o_ack_wr   (w_ack_wr),
    .o_word_idx (w_word_idx)
  );

  // Bus write data and byte enables are held by the master until ack, so they are used live.
  assign w_status_wr = w_ack_wr && (w_word_idx == WORD_STATUS) && OPB_BE[STATUS_BE];
  assign w_clr_ovr   = w_status_wr && OPB_DBus[CLR_OVR_DBIT];
  assign w_clr_cnt   = w_status_wr && OPB_DBus[CLR_CNT_DBIT];
  assign w_data_rd   = w_ack_rd && (w_word_idx == WORD_DATA);

  // A capture in the ack cycle wins over the read/W1C side effects of that ack.
  // NOTE: the published data word is an ordinary register, so it is cleared by
  // reset like the flags; only true RAM arrays are left out of reset.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      r_data <= '0;
      r_cnt  <= '0;
      r_new  <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_new <= user_data_valid | (r_new & ~w_data_rd);
      r_ovr <= (user_data_valid & r_new) | (r_ovr & ~w_clr_ovr);
      if (user_data_valid) begin
        r_data <= user_data_in;
        r_cnt  <= (w_clr_cnt ? '0 : r_cnt) + 1'b1;
      end else if (w_clr_cnt) begin
        r_cnt  <= '0;
      end
    end
  end

`ifdef SIM2PPC_TIMESTAMP_EN
  logic [31:0] r_cyc;
  logic [31:0] r_ts;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      r_cyc <= '0;
      r_ts  <= '0;
    end else begin
      r_cyc <= r_cyc + 32'd1;
      if (user_data_valid) r_ts <= r_cyc;
    end
  end

  assign w_ts_word = r_ts;
`else
  assign w_ts_word = '0;
`endif

  always_comb begin
    w_rd_word = '0;
    case (w_word_idx)
      WORD_DATA:   w_rd_word = r_data;
      WORD_STATUS: w_rd_word = pack_status(r_cnt, r_ovr, r_new);
      WORD_TS:     w_rd_word = w_ts_word;
      default:     w_rd_word = '0;
    endcase
  end

  // Read data is gated by the registered ack so the OR-bus sees zeros otherwise.
  assign Sl_DBus    = w_ack_rd ? w_rd_word : '0;
  assign Sl_xferAck = w_ack;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  // Inputs the register map never looks at.
  assign w_unused = ^{OPB_seqAddr, OPB_BE[0:STATUS_BE-1], OPB_DBus[0:CLR_CNT_DBIT-1], C_FAMILY};

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// Self-checking bench: directed scenarios plus randomized bus/capture traffic
// compared against a register-level behavioural model of the snapshot block.
module tb_opb_register_simulink2ppc_snap;

  localparam logic [31:0] BASE = 32'h0101_0800;
  localparam logic [31:0] HIGH = 32'h0101_08FF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:31] abus;
  logic [0:3]  be;
  logic [0:31] dbus;
  logic        rnw;
  logic        sel;
  logic        seq;
  logic [0:31] sl_dbus;
  logic        ack;
  logic        err_ack;
  logic        retry;
  logic        tout;
  logic [31:0] ud;
  logic        uv;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  logic [31:0] m_data;
  logic [15:0] m_cnt;
  bit          m_new;
  bit          m_ovr;
  logic [31:0] m_ts;
  logic [31:0] tb_cyc;

  always #5 clk = ~clk;

  opb_register_simulink2ppc_snap dut (
    .OPB_Clk         (clk),
    .OPB_Rst_n       (rst_n),
    .OPB_ABus        (abus),
    .OPB_BE          (be),
    .OPB_DBus        (dbus),
    .OPB_RNW         (rnw),
    .OPB_select      (sel),
    .OPB_seqAddr     (seq),
    .Sl_DBus         (sl_dbus),
    .Sl_xferAck      (ack),
    .Sl_errAck       (err_ack),
    .Sl_retry        (retry),
    .Sl_toutSup      (tout),
    .user_data_in    (ud),
    .user_data_valid (uv)
  );

  // Cycles elapsed since reset release, as a free-running counter would see them.
  always @(posedge clk) begin
    if (!rst_n) tb_cyc <= '0;
    else        tb_cyc <= tb_cyc + 32'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_data = '0; m_cnt = '0; m_new = 0; m_ovr = 0; m_ts = '0;
  endtask

  function automatic logic [31:0] model_word(input logic [1:0] idx);
    case (idx)
      2'd0: return m_data;
      2'd1: return {m_cnt, 14'b0, m_ovr, m_new};
`ifdef SIM2PPC_TIMESTAMP_EN
      2'd2: return m_ts;
`endif
      default: return 32'h0;
    endcase
  endfunction

  // Effects of one clock edge: bus side effects first, then a capture overrides them.
  task automatic model_edge(input bit rd_data, input bit clr_ovr, input bit clr_cnt,
                            input bit valid, input logic [31:0] v, input logic [31:0] ts);
    bit was_new;
    was_new = m_new;
    if (clr_ovr) m_ovr = 0;
    if (clr_cnt) m_cnt = '0;
    if (rd_data) m_new = 0;
    if (valid) begin
      m_data = v;
      m_cnt  = m_cnt + 16'd1;
      m_new  = 1;
      m_ts   = ts;
      if (was_new) m_ovr = 1;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; sel = 1'b0; uv = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_valid(input logic [31:0] v);
    logic [31:0] ts;
    @(negedge clk);
    uv = 1'b1; ud = v; ts = tb_cyc;
    @(negedge clk);
    uv = 1'b0;
    model_edge(0, 0, 0, 1, v, ts);
  endtask

  // One OPB transfer; optionally strobes a capture during the ack cycle.
  task automatic bus_xfer(input logic [31:0] addr, input bit rd, input logic [31:0] wdata,
                          input logic [3:0] be_v, input bit valid_in_ack,
                          input logic [31:0] vdata, output logic [31:0] rdata);
    int          lat;
    bit          got;
    logic [1:0]  idx;
    logic [31:0] exp;
    logic [31:0] ts;
    bit          sw;
    lat = 0; got = 0; idx = addr[3:2]; rdata = '0;
    @(negedge clk);
    abus = addr; rnw = rd; dbus = wdata; be = be_v; sel = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (ack) got = 1;
    end
    if (!got) begin
      check("ack_timeout", 32'd0, 32'd1);
      sel = 1'b0;
      return;
    end
    check("ack_latency", lat, 32'd1);
    rdata = sl_dbus;
    exp   = rd ? model_word(idx) : 32'h0;
    check(rd ? "rd_data" : "wr_dbus_zero", sl_dbus, exp);
    ts = tb_cyc;
    if (valid_in_ack) begin
      uv = 1'b1; ud = vdata;
    end
    sw = !rd && (idx == 2'd1) && be_v[0];
    model_edge(rd && idx == 2'd0, sw && wdata[0], sw && wdata[1], valid_in_ack, vdata, ts);
    @(negedge clk);
    uv = 1'b0;
    check("no_double_ack", {31'b0, ack}, 32'd0);
    check("dbus_after_ack", sl_dbus, 32'h0);
    sel = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_no_ack(input string tag, input logic [31:0] addr);
    int acks;
    acks = 0;
    @(negedge clk);
    abus = addr; rnw = 1'b1; sel = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (ack) acks++;
    end
    check({tag, "_dbus"}, sl_dbus, 32'h0);
    check({tag, "_acks"}, acks, 32'd0);
    sel = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          acks;
    int          wait_cnt;

    rst_n = 1'b0; abus = '0; be = '0; dbus = '0; rnw = 1'b0; sel = 1'b0;
    seq = 1'b0; ud = '0; uv = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ack",   {31'b0, ack},     32'd0);
    check("rst_dbus",  sl_dbus,          32'h0);
    check("rst_tied",  {29'b0, err_ack, retry, tout}, 32'd0);
    rst_n = 1'b1;

    // Scenario 1: capture then read DATA, then STATUS
    pulse_valid(32'hDEAD_BEEF);
    bus_xfer(BASE, 1, '0, 4'hF, 0, '0, rd);
    check("t1_data", rd, 32'hDEAD_BEEF);
    bus_xfer(BASE + 32'd4, 1, '0, 4'hF, 0, '0, rd);
    check("t1_status", rd, 32'h0001_0000);

    // Scenario 2: overrun, then W1C of overrun only
    apply_reset();
    pulse_valid(32'h1111_2222);
    pulse_valid(32'h3333_4444);
    bus_xfer(BASE + 32'd4, 1, '0, 4'hF, 0, '0, rd);
    check("t2_status", rd, 32'h0002_0003);
    bus_xfer(BASE + 32'd4, 0, 32'h0000_0001, 4'b0001, 0, '0, rd);
    bus_xfer(BASE + 32'd4, 1, '0, 4'hF, 0, '0, rd);
    check("t2_w1c", rd, 32'h0002_0001);

    // Scenario 3: capture coincides with DATA read ack
    bus_xfer(BASE, 1, '0, 4'hF, 1, 32'h5555_AAAA, rd);
    check("t3_old", rd, 32'h3333_4444);
    bus_xfer(BASE + 32'd4, 1, '0, 4'hF, 0, '0, rd);
    check("t3_new_kept", {31'b0, rd[0]}, 32'd1);
    bus_xfer(BASE, 1, '0, 4'hF, 0, '0, rd);
    check("t3_newval", rd, 32'h5555_AAAA);

    // Scenario 4: select held 5 cycles, boundaries and misses
    @(negedge clk);
    abus = BASE + 32'd4; rnw = 1'b1; sel = 1'b1;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ack) begin
        acks++;
        check("hold_rd", sl_dbus, model_word(2'd1));
      end else begin
        check("hold_dbus_zero", sl_dbus, 32'h0);
      end
    end
    check("hold_acks", acks, 32'd1);
    sel = 1'b0;
    @(negedge clk);
    bus_xfer(HIGH, 1, '0, 4'hF, 0, '0, rd);
    check("high_reserved", rd, 32'h0);
    expect_no_ack("above_high", HIGH + 32'd1);
    expect_no_ack("below_base", BASE - 32'd1);

    // Scenario 5: reset during the ack-pending cycle
    pulse_valid(32'hCAFE_F00D);
    @(negedge clk);
    abus = BASE; rnw = 1'b1; sel = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack) acks++;
    end
    check("rst_mid_acks", acks, 32'd0);
    sel = 1'b0;
    rst_n = 1'b1;
    bus_xfer(BASE + 32'd4, 1, '0, 4'hF, 0, '0, rd);
    check("rst_mid_status", rd, 32'h0);
    bus_xfer(BASE, 1, '0, 4'hF, 0, '0, rd);
    check("rst_mid_data", rd, 32'h0);
    bus_xfer(BASE + 32'd8, 1, '0, 4'hF, 0, '0, rd);

`ifdef SIM2PPC_TIMESTAMP_EN
    // Capture at cycle 100 after reset release
    apply_reset();
    wait_cnt = 0;
    while (tb_cyc != 32'd100 && wait_cnt < 400) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("ts_wait", {31'b0, wait_cnt < 400}, 32'd1);
    uv = 1'b1; ud = 32'h0000_0064;
    model_edge(0, 0, 0, 1, 32'h0000_0064, tb_cyc);
    @(negedge clk);
    uv = 1'b0;
    bus_xfer(BASE + 32'd8, 1, '0, 4'hF, 0, '0, rd);
    check("ts_cycle100", rd, 32'd100);
`else
    wait_cnt = 0;
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 250; n++) begin
      logic [31:0] addr;
      int          op;
      op   = $urandom_range(0, 4);
      addr = BASE + {24'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      case (op)
        0: pulse_valid($urandom);
        1: bus_xfer(addr, 1, '0, 4'($urandom), 0, '0, rd);
        2: bus_xfer({addr[31:4], 4'h4}, 0, {30'($urandom), 2'($urandom_range(0, 3))},
                    4'($urandom), 0, '0, rd);
        3: bus_xfer({addr[31:4], 4'h0}, 1, '0, 4'hF, 1, $urandom, rd);
        default: bus_xfer(addr, 0, $urandom, 4'($urandom), $urandom_range(0, 1), $urandom, rd);
      endcase
    end
    bus_xfer(BASE + 32'd4, 1, '0, 4'hF, 0, '0, rd);
    check("final_status", rd, model_word(2'd1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
